// File: rtl/muldiv_if.sv
// Request/response bundle between the core and the iterative mul/div unit.
//   start/op/a/b          : request, driven by the core (master)
//   busy/done/result/zero/err : status and response, driven by the unit (slave)
// WIDTH must match the WIDTH of the attached iterative_muldiv.
interface muldiv_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             err;

  modport master (output start, op, a, b, input busy, done, result, zero, err);
  modport slave  (input start, op, a, b, output busy, done, result, zero, err);
endinterface

// File: rtl/iterative_muldiv.sv
// Multi-cycle integer multiply/divide unit (radix-2 shift-add multiply,
// restoring divide). Ops: 000 MUL, 001 UMULH, 010 SMULH, 011 UDIV, 100 SDIV,
// 101 UREM; 110/111 illegal.
// Ports:
//   clk     : clock, rising edge
//   reset_n : synchronous active-low reset
//   bus     : muldiv_if.slave (start/op/a/b in; busy/done/result/zero/err out)
// Build option: define MULDIV_SIGNED_EN to enable SMULH/SDIV (sign
// magnitude pre/post processing); without it 010/100 complete as illegal ops.
// Timing: start accepted at edge N -> done after edge N+WIDTH+1 (faulting
// requests: after edge N+1). busy is high only while iterating.
module iterative_muldiv #(
  parameter int WIDTH = 64
) (
  input logic     clk,
  input logic     reset_n,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MUL   = 3'b000;
  localparam logic [2:0] OP_UMULH = 3'b001;
  localparam logic [2:0] OP_SMULH = 3'b010;
  localparam logic [2:0] OP_UDIV  = 3'b011;
  localparam logic [2:0] OP_SDIV  = 3'b100;
  localparam logic [2:0] OP_UREM  = 3'b101;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [2:0]       op_q;
  logic             fault_q;
  logic             is_div_q;
  // hi: upper product half / partial remainder
  // lo: multiplier shifting out, low product half shifting in / dividend -> quotient
  logic [WIDTH-1:0] hi, lo, mcand;
`ifdef MULDIV_SIGNED_EN
  logic             neg_q;
`endif

  // Request decode, evaluated on the live inputs while IDLE.
  logic             op_legal, op_div, op_fault;
  logic [WIDTH-1:0] a_mag, b_mag;
`ifdef MULDIV_SIGNED_EN
  logic             op_signed, neg_nx;
`endif

  always_comb begin
    op_legal = 1'b0;
    case (bus.op)
      OP_MUL, OP_UMULH, OP_UDIV, OP_UREM: op_legal = 1'b1;
`ifdef MULDIV_SIGNED_EN
      OP_SMULH, OP_SDIV:                  op_legal = 1'b1;
`endif
      default:                            op_legal = 1'b0;
    endcase
    op_div   = (bus.op == OP_UDIV) || (bus.op == OP_SDIV) || (bus.op == OP_UREM);
    op_fault = !op_legal || (op_div && (bus.b == '0));
`ifdef MULDIV_SIGNED_EN
    // Signed ops iterate on magnitudes; the sign is reapplied in FIN.
    op_signed = (bus.op == OP_SMULH) || (bus.op == OP_SDIV);
    a_mag     = (op_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_mag     = (op_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    neg_nx    = op_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
`else
    a_mag = bus.a;
    b_mag = bus.b;
`endif
  end

  // One iteration of each datapath.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_sub;

  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    rem_sh  = {hi, lo[WIDTH-1]};
    rem_ge  = rem_sh >= {1'b0, mcand};
    // The difference is below the divisor when taken, so WIDTH bits suffice.
    rem_sub = rem_sh[WIDTH-1:0] - mcand;
  end

  // Final result selection / sign fix-up.
  logic [WIDTH-1:0] fin_res;
`ifdef MULDIV_SIGNED_EN
  logic [WIDTH-1:0] hi_neg;
`endif

  always_comb begin
`ifdef MULDIV_SIGNED_EN
    // Upper half of -{hi,lo}: carry from the low half only when lo is zero.
    hi_neg = ~hi + WIDTH'(lo == '0);
`endif
    fin_res = '0;
    if (fault_q) begin
      // lo still holds the untouched dividend on the fast path.
      fin_res = (op_q == OP_UREM) ? lo : '0;
    end else begin
      case (op_q)
        OP_MUL:   fin_res = lo;
        OP_UMULH: fin_res = hi;
        OP_UDIV:  fin_res = lo;
        OP_UREM:  fin_res = hi;
`ifdef MULDIV_SIGNED_EN
        OP_SMULH: fin_res = neg_q ? hi_neg : hi;
        OP_SDIV:  fin_res = neg_q ? -lo : lo;
`endif
        default:  fin_res = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      op_q       <= OP_MUL;
      fault_q    <= 1'b0;
      is_div_q   <= 1'b0;
      hi         <= '0;
      lo         <= '0;
      mcand      <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_q      <= 1'b0;
`endif
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
      bus.zero   <= 1'b1;
      bus.err    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          // The done cycle still counts as completion: a start there is dropped.
          if (bus.start && !bus.done) begin
            op_q     <= bus.op;
            fault_q  <= op_fault;
            is_div_q <= op_div;
            hi       <= '0;
            lo       <= a_mag;
            mcand    <= b_mag;
            cnt      <= CW'(WIDTH - 1);
`ifdef MULDIV_SIGNED_EN
            neg_q    <= neg_nx;
`endif
            bus.busy <= !op_fault;
            state    <= op_fault ? FIN : RUN;
          end
        end
        RUN: begin
          if (is_div_q) begin
            hi <= rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
            lo <= {lo[WIDTH-2:0], rem_ge};
          end else begin
            hi <= mul_sum[WIDTH:1];
            lo <= {mul_sum[0], lo[WIDTH-1:1]};
          end
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            bus.busy <= 1'b0;
            state    <= FIN;
          end
        end
        FIN: begin
          bus.result <= fin_res;
          bus.zero   <= (fin_res == '0);
          bus.err    <= fault_q;
          bus.done   <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iterative_muldiv.sv
// Scoreboard bench for iterative_muldiv (WIDTH=64): the driver pushes the
// reference result of each accepted request; a negedge monitor pops on done
// and checks result/zero/err, start->done latency and busy length.
module tb_iterative_muldiv;
  localparam int W = 64;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           start_cyc;
    int           lat;
    int           busyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(W)) bus ();
  iterative_muldiv #(.WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference: plain double-width arithmetic on the operands.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [2*W-1:0] up;
`ifdef MULDIV_SIGNED_EN
    logic signed [2*W-1:0] sa, sbv, sr;
    sa  = $signed({{W{a[W-1]}}, a});
    sbv = $signed({{W{b[W-1]}}, b});
`endif
    e.res = '0; e.err = 1'b0; e.start_cyc = 0; e.lat = W + 1; e.busyc = W;
    up = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (op)
      3'd0: e.res = up[W-1:0];
      3'd1: e.res = up[2*W-1:W];
      3'd3: if (b == 0) e.err = 1'b1; else e.res = a / b;
      3'd5: if (b == 0) begin e.err = 1'b1; e.res = a; end else e.res = a % b;
`ifdef MULDIV_SIGNED_EN
      3'd2: begin sr = sa * sbv; e.res = sr[2*W-1:W]; end
      3'd4: if (b == 0) e.err = 1'b1; else begin sr = sa / sbv; e.res = sr[W-1:0]; end
`endif
      default: e.err = 1'b1;
    endcase
    if (e.err) begin e.lat = 1; e.busyc = 0; end
    return e;
  endfunction

  // Monitor: checks every done pulse against the oldest outstanding request.
  always @(negedge clk) begin
    if (!reset_n) begin
      busy_cnt = 0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: result %0h with no request outstanding", bus.result);
        end else begin
          mon_e = sb.pop_front();
          chk("result", bus.result, mon_e.res);
          chk("err", W'(bus.err), W'(mon_e.err));
          chk("zero", W'(bus.zero), W'(mon_e.res == 0));
          chk("latency", W'(cyc - mon_e.start_cyc), W'(mon_e.lat));
          chk("busy_cycles", W'(busy_cnt), W'(mon_e.busyc));
        end
        busy_cnt = 0;
      end
    end
  end

  // Issue one request; poke=1 also pulses start while the op is in flight
  // and again on the done cycle, neither of which may be accepted.
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
    exp_t e;
    bit   got;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    e = model(op, a, b);
    e.start_cyc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    bus.op = 3'($urandom); bus.a = {$urandom, $urandom}; bus.b = {$urandom, $urandom};
    bus.start = poke;
    if (poke) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (bus.done) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL done_timeout: got no done, expected one within 200 cycles (op %0d)", op);
    end
    if (poke) begin
      bus.start = 1'b1; bus.op = 3'd0; bus.a = 1; bus.b = 1;
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  initial begin
    logic [2:0]   rop;
    logic [W-1:0] ra, rb;
    bus.start = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", W'(bus.busy), 0);
    chk("rst_done", W'(bus.done), 0);
    chk("rst_result", bus.result, 0);
    chk("rst_zero", W'(bus.zero), 1);
    chk("rst_err", W'(bus.err), 0);
    reset_n = 1'b1;

    do_op(3'd0, 7, 6, 0);
    do_op(3'd1, '1, '1, 0);
    do_op(3'd0, '1, '1, 0);
    do_op(3'd3, 100, 7, 0);
    do_op(3'd5, 100, 7, 0);
    do_op(3'd3, 5, 0, 0);
    do_op(3'd5, 5, 0, 0);
    do_op(3'd0, 0, 99, 0);
    do_op(3'd6, 12, 3, 0);
    do_op(3'd7, 12, 3, 0);
`ifdef MULDIV_SIGNED_EN
    do_op(3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 2, 0);
    do_op(3'd2, '1, 1, 0);
    do_op(3'd4, 64'h8000_0000_0000_0000, '1, 0);
    do_op(3'd4, 5, 0, 0);
`else
    do_op(3'd2, 5, 3, 0);
    do_op(3'd4, 100, 7, 0);
`endif
    do_op(3'd0, 123, 456, 1);
    do_op(3'd3, 5, 0, 1);

    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 1000)) : {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 20));
        2:       rb = '1;
        default: rb = {$urandom, $urandom};
      endcase
      do_op(rop, ra, rb, n[2:0] == 3'd5);
    end

    // Abort mid-RUN: nothing may complete and the outputs return to reset values.
    do_op(3'd0, 3, 5, 0);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 9; bus.b = 9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("abort_busy", W'(bus.busy), 0);
    chk("abort_done", W'(bus.done), 0);
    chk("abort_result", bus.result, 0);
    chk("abort_zero", W'(bus.zero), 1);
    chk("abort_err", W'(bus.err), 0);
    reset_n = 1'b1;
    repeat (80) @(negedge clk);
    do_op(3'd0, 7, 6, 0);
    do_op(3'd5, 100, 7, 0);

    repeat (3) @(negedge clk);
    chk("outstanding", W'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
